// File: rtl/led_sequencer.sv
// led_sequencer: drives single-cycle register writes into led_interface so the
// LEDs show an OFF, STATIC, BLINK or CHASE pattern paced by a prescaled step timebase.
module led_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int PERIOD_W = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_write_req,
   input  logic [1:0]  cfg_addr,
   input  logic [31:0] cfg_write_data,
   output logic        led_write_req,
   output logic [31:0] led_write_data,
   output logic [3:0]  led_byte_enable,
   output logic        led_read_req,
   output logic        busy
);

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_STATIC = 2'd1;
   localparam logic [1:0] MODE_BLINK  = 2'd2;
   localparam logic [1:0] MODE_CHASE  = 2'd3;

   localparam logic [1:0] ADDR_MODE    = 2'd0;
   localparam logic [1:0] ADDR_PATTERN = 2'd1;
   localparam logic [1:0] ADDR_PERIOD  = 2'd2;
   localparam logic [1:0] ADDR_RSVD    = 2'd3;

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [1:0]          mode_q,     mode_d;
   logic [3:0]          pattern_q,  pattern_d;
   logic [PERIOD_W-1:0] period_q,   period_d;
   logic [PRESC_W-1:0]  presc_q,    presc_d;
   logic [PERIOD_W-1:0] step_cnt_q, step_cnt_d;
   logic                phase_q,    phase_d;
   logic [3:0]          rot_q,      rot_d;
   logic                pending_q,  pending_d;
   logic [0:0]          state_q,    state_d;
   logic [3:0]          value_q,    value_d;

   logic       cfg_valid;
   logic       tick;
   logic       step;
   logic       trigger;
   logic [3:0] cur_value;
   logic       unused_cfg_bits;

   assign unused_cfg_bits = ^cfg_write_data[31:PERIOD_W];

   assign cfg_valid = cfg_write_req && (cfg_addr != ADDR_RSVD);
   assign tick      = (presc_q == PRESC_MAX);
   assign step      = tick && (step_cnt_q == period_q);

   always_comb begin
      mode_d    = mode_q;
      pattern_d = pattern_q;
      period_d  = period_q;
      if (cfg_write_req) begin
         case (cfg_addr)
            ADDR_MODE:    mode_d    = cfg_write_data[1:0];
            ADDR_PATTERN: pattern_d = cfg_write_data[3:0];
            ADDR_PERIOD:  period_d  = cfg_write_data[PERIOD_W-1:0];
            default:      ;
         endcase
      end
   end

   // A config write restarts the timebase and swallows any step on the same edge.
   always_comb begin
      presc_d    = presc_q;
      step_cnt_d = step_cnt_q;
      phase_d    = phase_q;
      rot_d      = rot_q;
      if (cfg_valid) begin
         presc_d    = '0;
         step_cnt_d = '0;
         phase_d    = 1'b0;
         rot_d      = pattern_d;
      end else begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            step_cnt_d = (step_cnt_q == period_q) ? '0 : step_cnt_q + 1'b1;
         end
         if (step && (mode_q == MODE_BLINK)) begin
            phase_d = ~phase_q;
         end
         if (step && (mode_q == MODE_CHASE)) begin
            rot_d = {rot_q[2:0], rot_q[3]};
         end
      end
   end

   assign trigger = cfg_valid ||
                    (step && ((mode_q == MODE_BLINK) || (mode_q == MODE_CHASE)));

   always_comb begin
      case (mode_q)
         MODE_STATIC: cur_value = pattern_q;
         MODE_BLINK:  cur_value = phase_q ? 4'h0 : pattern_q;
         MODE_CHASE:  cur_value = rot_q;
         default:     cur_value = 4'h0;
      endcase
   end

   // A trigger on the servicing edge keeps pending set, so the newer value follows.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      value_d   = value_q;
      case (state_q)
         ST_RUN: begin
            if (pending_q) begin
               value_d   = cur_value;
               pending_d = 1'b0;
               state_d   = ST_EMIT;
            end
         end
         ST_EMIT: state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
      if (trigger) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q     <= MODE_OFF;
         pattern_q  <= 4'h1;
         period_q   <= '0;
         presc_q    <= '0;
         step_cnt_q <= '0;
         phase_q    <= 1'b0;
         rot_q      <= 4'h1;
         pending_q  <= 1'b1;
         state_q    <= ST_RUN;
         value_q    <= 4'h0;
      end else begin
         mode_q     <= mode_d;
         pattern_q  <= pattern_d;
         period_q   <= period_d;
         presc_q    <= presc_d;
         step_cnt_q <= step_cnt_d;
         phase_q    <= phase_d;
         rot_q      <= rot_d;
         pending_q  <= pending_d;
         state_q    <= state_d;
         value_q    <= value_d;
      end
   end

   assign led_write_req   = (state_q == ST_EMIT);
   assign led_write_data  = {28'h0, value_q};
   assign led_byte_enable = 4'h1;
   assign led_read_req    = 1'b0;
   assign busy            = pending_q || (state_q == ST_EMIT);

endmodule
